bp_be_nonsynth_cmt_checker: RTL and testbench

Nonsynthesizable back-end commit checker. It consumes the core's per-instruction commit stream and compares each commit, in order, against a golden commit record stream, e.g. one replayed from a previously written commit trace by a testbench ROM. It sits beside the BE calculator in the testbench and reports pass, fail, mismatch and overflow status. It never back-pressures the core: commits are buffered in a small FIFO until a golden record is available.

---
 rtl/bp_be_pkg.sv | 36 +++
 rtl/bsg_fifo_1r1w_small.sv | 47 ++++
 rtl/bp_be_nonsynth_cmt_checker.sv | 140 ++++++++++++++
 tb/tb_bp_be_nonsynth_cmt_checker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - back-end checker types, commit record macros and config helpers
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2((x)))
`endif

`define DECLARE_BP_BE_CMT_REC_S(vaddr_width_mp) \
  typedef struct packed { \
    logic [vaddr_width_mp-1:0] pc; \
    logic [31:0]               instr; \
    logic                      rd_w_v; \
    logic [4:0]                rd_addr; \
    logic [63:0]               rd_data; \
  } bp_be_cmt_rec_s

`define BP_BE_CMT_REC_WIDTH(vaddr_width_mp) ((vaddr_width_mp) + 32 + 1 + 5 + 64)

package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg     = 2'd0,
    e_bp_default_cfg = 2'd1
  } bp_params_e;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_run  = 2'd1,
    e_pass = 2'd2,
    e_fail = 2'd3
  } bp_be_cmt_chk_state_e;

  // Both supported configurations use Sv39 virtual addresses.
  function automatic int bp_vaddr_width(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? 39 : 39;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small register-based FIFO with valid/ready enqueue and yumi dequeue
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = `BSG_SAFE_CLOG2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  assign ready_o = (count_r != cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (deq) rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      if (enq & ~deq)      count_r <= count_r + 1'b1;
      else if (deq & ~enq) count_r <= count_r - 1'b1;
    end
  end

endmodule

// File: rtl/bp_be_nonsynth_cmt_checker.sv
// rtl/bp_be_nonsynth_cmt_checker.sv - compares the core commit stream against a golden record stream
module bp_be_nonsynth_cmt_checker
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_inv_cfg,
  parameter int         num_core_p     = 1,
  parameter int         fifo_els_p     = 8,
  parameter int         max_mismatch_p = 1,
  parameter int         timeout_p      = 1024,
  parameter int         cnt_width_p    = 32,
  localparam int        vaddr_width_p  = bp_vaddr_width(bp_params_p),
  localparam int        hart_w_lp      = `BSG_SAFE_CLOG2(num_core_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     freeze_i,
  input  logic [hart_w_lp-1:0]     mhartid_i,
  input  logic                     commit_v_i,
  input  logic [vaddr_width_p-1:0] commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic                     commit_rd_w_v_i,
  input  logic [4:0]               commit_rd_addr_i,
  input  logic [63:0]              commit_rd_data_i,
  input  logic                     gold_v_i,
  output logic                     gold_ready_o,
  input  logic [vaddr_width_p-1:0] gold_pc_i,
  input  logic [31:0]              gold_instr_i,
  input  logic                     gold_rd_w_v_i,
  input  logic [4:0]               gold_rd_addr_i,
  input  logic [63:0]              gold_rd_data_i,
  input  logic                     gold_last_i,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     overflow_o,
  output logic                     timeout_o,
  output logic [cnt_width_p-1:0]   commit_cnt_o,
  output logic [cnt_width_p-1:0]   mismatch_cnt_o,
  output logic [vaddr_width_p-1:0] fail_pc_o
);

  `DECLARE_BP_BE_CMT_REC_S(vaddr_width_p);
  localparam int rec_width_lp = `BP_BE_CMT_REC_WIDTH(vaddr_width_p);
  localparam int tmr_w_lp     = $clog2(timeout_p + 1);

  bp_be_cmt_rec_s commit_rec, gold_rec, head_rec;
  logic [rec_width_lp-1:0] head_bits;
  logic fifo_v, fifo_ready;
  logic active, enq, cmp, match, overflow_set, timeout_set, mismatch_limit;
  logic [cnt_width_p-1:0] mismatch_cnt_n;
  logic [tmr_w_lp-1:0]    timer_r;
  bp_be_cmt_chk_state_e   state_r, state_n;

  assign commit_rec = '{pc: commit_pc_i, instr: commit_instr_i, rd_w_v: commit_rd_w_v_i,
                        rd_addr: commit_rd_addr_i, rd_data: commit_rd_data_i};
  assign gold_rec   = '{pc: gold_pc_i, instr: gold_instr_i, rd_w_v: gold_rd_w_v_i,
                        rd_addr: gold_rd_addr_i, rd_data: gold_rd_data_i};
  assign head_rec   = head_bits;

  // Overflow is judged against the pre-dequeue occupancy, so a full FIFO never accepts.
  assign active         = (state_r == e_run) & ~freeze_i;
  assign enq            = active & commit_v_i & fifo_ready;
  assign overflow_set   = active & commit_v_i & ~fifo_ready;
  assign cmp            = active & fifo_v & gold_v_i;
  assign timeout_set    = active & ~cmp & (timer_r == tmr_w_lp'(timeout_p - 1));
  assign mismatch_cnt_n = (cmp & ~match & ~(&mismatch_cnt_o)) ? mismatch_cnt_o + 1'b1 : mismatch_cnt_o;
  assign mismatch_limit = cmp & ~match & (mismatch_cnt_n >= cnt_width_p'(max_mismatch_p));

  // Writes to x0 carry no architectural effect, so their address and data are don't-cares.
  always_comb begin
    match = (head_rec.pc == gold_rec.pc)
          & (head_rec.instr == gold_rec.instr)
          & (head_rec.rd_w_v == gold_rec.rd_w_v);
    if (gold_rec.rd_w_v && (gold_rec.rd_addr != 5'd0))
      match = match & (head_rec.rd_addr == gold_rec.rd_addr)
                    & (head_rec.rd_data == gold_rec.rd_data);
  end

  bsg_fifo_1r1w_small #(
    .width_p(rec_width_lp),
    .els_p  (fifo_els_p)
  ) cmt_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (enq),
    .ready_o(fifo_ready),
    .data_i (commit_rec),
    .v_o    (fifo_v),
    .data_o (head_bits),
    .yumi_i (cmp)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle: if (!freeze_i) state_n = e_run;
      e_run: begin
        if (overflow_set | timeout_set | mismatch_limit) state_n = e_fail;
        else if (cmp & match & gold_last_i)              state_n = e_pass;
      end
      default: state_n = state_r;
    endcase
  end

  always_comb begin
    gold_ready_o = fifo_v & (state_r == e_run);
    pass_o       = (state_r == e_pass);
    fail_o       = (state_r == e_fail);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_o     <= 1'b0;
      timeout_o      <= 1'b0;
      commit_cnt_o   <= '0;
      mismatch_cnt_o <= '0;
      fail_pc_o      <= '0;
      timer_r        <= '0;
    end else begin
      if (overflow_set) overflow_o <= 1'b1;
      if (timeout_set)  timeout_o  <= 1'b1;
      if (active)       timer_r    <= cmp ? '0 : timer_r + 1'b1;
      if (cmp & ~(&commit_cnt_o)) commit_cnt_o <= commit_cnt_o + 1'b1;
      if (cmp & ~match & (mismatch_cnt_o == '0)) fail_pc_o <= gold_rec.pc;
      mismatch_cnt_o <= mismatch_cnt_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && cmp && !match)
      $display("[hart %0d] commit mismatch: dut pc=%h instr=%h w=%b rd=%0d data=%h | gold pc=%h instr=%h w=%b rd=%0d data=%h | count=%0d",
               mhartid_i, head_rec.pc, head_rec.instr, head_rec.rd_w_v, head_rec.rd_addr, head_rec.rd_data,
               gold_rec.pc, gold_rec.instr, gold_rec.rd_w_v, gold_rec.rd_addr, gold_rec.rd_data, mismatch_cnt_n);
  end

endmodule

// File: tb/tb_bp_be_nonsynth_cmt_checker.sv
// tb/tb_bp_be_nonsynth_cmt_checker.sv - directed self-checking bench for the commit checker
module tb_bp_be_nonsynth_cmt_checker;

  typedef struct packed {
    logic [38:0] pc;
    logic [31:0] instr;
    logic        w;
    logic [4:0]  rd;
    logic [63:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        freeze = 1'b0;
  logic [0:0]  hart = 1'b0;
  logic        commit_v = 1'b0;
  rec_t        c = '0;
  rec_t        g = '0;
  logic        gold_v = 1'b0;
  logic        gold_last = 1'b0;
  logic        gold_ready, pass, fail, overflow, timeout;
  logic [31:0] commit_cnt, mismatch_cnt;
  logic [38:0] fail_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_be_nonsynth_cmt_checker dut (
    .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .mhartid_i(hart),
    .commit_v_i(commit_v), .commit_pc_i(c.pc), .commit_instr_i(c.instr),
    .commit_rd_w_v_i(c.w), .commit_rd_addr_i(c.rd), .commit_rd_data_i(c.data),
    .gold_v_i(gold_v), .gold_ready_o(gold_ready), .gold_pc_i(g.pc), .gold_instr_i(g.instr),
    .gold_rd_w_v_i(g.w), .gold_rd_addr_i(g.rd), .gold_rd_data_i(g.data), .gold_last_i(gold_last),
    .pass_o(pass), .fail_o(fail), .overflow_o(overflow), .timeout_o(timeout),
    .commit_cnt_o(commit_cnt), .mismatch_cnt_o(mismatch_cnt), .fail_pc_o(fail_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rec_t mk(input int i);
    rec_t r;
    r.pc    = 39'h8000_0000 + 39'(4 * i);
    r.instr = 32'h0000_0013 | (32'(i) << 20);
    r.w     = 1'b1;
    r.rd    = 5'((i % 31) + 1);
    r.data  = 64'h1000 + 64'(i);
    return r;
  endfunction

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Enqueue a commit one cycle, then present the golden record the next.
  task automatic send(input rec_t cr, input rec_t gr, input logic last);
    commit_v = 1'b1; c = cr; gold_v = 1'b0;
    step();
    commit_v = 1'b0; gold_v = 1'b1; g = gr; gold_last = last;
    step();
    gold_v = 1'b0; gold_last = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1; commit_v = 1'b0; gold_v = 1'b0; gold_last = 1'b0; freeze = 1'b0;
    step(2);
    reset = 1'b0;
    step();
  endtask

  initial begin
    rec_t bad;
    @(negedge clk);
    step(2);
    check("reset_pass", pass, 0);
    check("reset_fail", fail, 0);
    check("reset_commit_cnt", commit_cnt, 0);
    check("reset_fail_pc", fail_pc, 0);
    reset = 1'b0;
    step();

    // Ten matching records; a freeze window in the middle must hold everything.
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        commit_v = 1'b1; c = mk(i); step(); commit_v = 1'b0;
        freeze = 1'b1; gold_v = 1'b1; g = mk(i);
        step(3);
        check("freeze_holds_cnt", commit_cnt, 5);
        freeze = 1'b0;
        step();
        gold_v = 1'b0;
        check("unfreeze_cmp", commit_cnt, 6);
      end else begin
        send(mk(i), mk(i), i == 9);
      end
      if (i == 8) check("pass_before_last", pass, 0);
    end
    check("pass_10", pass, 1);
    check("cnt_10", commit_cnt, 10);
    check("mism_10", mismatch_cnt, 0);
    check("fail_10", fail, 0);

    // rd_data mismatch on the fourth commit.
    restart();
    for (int i = 0; i < 4; i++) begin
      bad = mk(i);
      if (i == 3) begin bad.rd = 5'd3; bad.data = 64'h5; end
      g = mk(i);
      if (i == 3) begin g.rd = 5'd3; g.data = 64'h6; end
      send(bad, g, 1'b0);
    end
    check("mm_fail", fail, 1);
    check("mm_cnt", mismatch_cnt, 1);
    check("mm_fail_pc", fail_pc, 64'(mk(3).pc));
    commit_v = 1'b1; c = mk(4); gold_v = 1'b1; g = mk(4);
    step();
    check("mm_ready_after_fail", gold_ready, 0);
    commit_v = 1'b0; gold_v = 1'b0;
    send(mk(5), mk(5), 1'b0);
    check("mm_ignored_cnt", commit_cnt, 4);
    check("mm_pass", pass, 0);

    // x0 write data is a don't-care.
    restart();
    bad = mk(0); bad.rd = 5'd0; bad.data = 64'hdead;
    g = bad; g.data = 64'h0;
    send(bad, g, 1'b1);
    check("x0_pass", pass, 1);
    check("x0_mism", mismatch_cnt, 0);

    // Nine commits with no golden records into an 8-deep buffer.
    restart();
    commit_v = 1'b1;
    for (int i = 0; i < 8; i++) begin c = mk(i); step(); end
    check("ovf_at_8", overflow, 0);
    check("ovf_fail_at_8", fail, 0);
    c = mk(8); step();
    commit_v = 1'b0;
    check("ovf_at_9", overflow, 1);
    check("ovf_fail_at_9", fail, 1);

    // Golden valid with an empty buffer until the timeout fires.
    restart();
    gold_v = 1'b1; g = mk(0);
    step(1023);
    check("tmo_before", timeout, 0);
    step();
    gold_v = 1'b0;
    check("tmo_fire", timeout, 1);
    check("tmo_fail", fail, 1);

    // Reset mid-run, then a fresh three-record run.
    restart();
    for (int i = 0; i < 5; i++) send(mk(i), mk(i), 1'b0);
    check("pre_reset_cnt", commit_cnt, 5);
    commit_v = 1'b1; c = mk(5);
    step();
    commit_v = 1'b0;
    reset = 1'b1;
    step();
    check("rst_cnt", commit_cnt, 0);
    check("rst_ready", gold_ready, 0);
    check("rst_flags", {pass, fail, overflow, timeout}, 0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) send(mk(20 + i), mk(20 + i), i == 2);
    check("fresh_pass", pass, 1);
    check("fresh_cnt", commit_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
